// File: rtl/l2_arb_pkg.sv
// Shared types and widths for the L2 port arbiter.
// Optional build macro used elsewhere: ARB_ROUND_ROBIN_EN.
package l2_arb_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// I-side, D-side and L2-side memory port signals for the L2 port arbiter.
// slave is the arbiter's view; master is the view of the caches plus L2.
interface l2_port_arbiter_if;
    import l2_arb_pkg::*;

    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/l2_arb_pick.sv
// Combinational grant select between I-side and D-side requests.
// ARB_ROUND_ROBIN_EN: alternate on collisions using rr_last; otherwise D-side always wins.
module l2_arb_pick
    import l2_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_t rr_last,
`endif
    input  logic   i_req,
    input  logic   d_req,
    output owner_t gnt_owner,
    output logic   gnt_valid
);

    always_comb begin
        gnt_valid = i_req | d_req;
        gnt_owner = d_req ? OWN_D : OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            gnt_owner = (rr_last == OWN_D) ? OWN_I : OWN_D;
        end
`endif
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 block port between the I-cache and D-cache, one whole transaction at a time.
// Build macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed D-over-I priority.
module l2_port_arbiter
    import l2_arb_pkg::*;
(
    input logic             clk,
    input logic             proc_reset_n,
    l2_port_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    owner_t            owner;
    owner_t            gnt_owner;
    logic              gnt_valid;
    logic              grant;
    logic              complete;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t            rr_last;
`endif

    l2_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .rr_last   (rr_last),
`endif
        .i_req     (bus.i_read | bus.i_write),
        .d_req     (bus.d_read | bus.d_write),
        .gnt_owner (gnt_owner),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        grant        = 1'b0;
        complete     = 1'b0;
        bus.i_ready  = 1'b0;
        bus.d_ready  = 1'b0;
        bus.i_rdata  = '0;
        bus.d_rdata  = '0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    grant     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    complete  = 1'b1;
                    state_nxt = DONE;
                    if (owner == OWN_D) begin
                        bus.d_ready = 1'b1;
                        bus.d_rdata = bus.mem_rdata;
                    end else begin
                        bus.i_ready = 1'b1;
                        bus.i_rdata = bus.mem_rdata;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write wins over read when one side raises both; the read is simply dropped.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            owner       <= OWN_D;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (grant) begin
            owner <= gnt_owner;
            if (gnt_owner == OWN_D) begin
                mem_write_q <= bus.d_write;
                mem_read_q  <= bus.d_read & ~bus.d_write;
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
            end else begin
                mem_write_q <= bus.i_write;
                mem_read_q  <= bus.i_read & ~bus.i_write;
                mem_addr_q  <= bus.i_addr;
                mem_wdata_q <= bus.i_wdata;
            end
        end else if (complete) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            rr_last <= OWN_D;
        end else if (grant) begin
            rr_last <= gnt_owner;
        end
    end
`endif

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
